// File: rtl/axis_gen_pkg.sv
// Shared types and constants for the AXI4-Stream packet generator.
// LFSR constants are used only when AXIS_PACKET_GEN_LFSR_EN is defined.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [63:0] LFSR_SEED = 64'hACE1_2468_1357_BDF9;
    // Right-shifting Galois form; taps 64,63,61,60 map to bits 63,62,60,59.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/axis_lfsr.sv
// 64-bit Galois LFSR with synchronous seed load and single-step advance.
// o_next is the state that the next advance will produce.
module axis_lfsr
    import axis_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [63:0] o_state,
    output logic [63:0] o_next
);

    logic [63:0] r_state;
    logic [63:0] w_next;

    assign w_next  = lfsr_next(r_state);
    assign o_state = r_state;
    assign o_next  = w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= LFSR_SEED;
        end else if (i_advance) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/axis_packet_gen.sv
// AXI4-Stream packet-run generator: configurable length, count and gap.
// Define AXIS_PACKET_GEN_LFSR_EN for an LFSR payload instead of a word counter.
module axis_packet_gen
    import axis_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 2,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned TUSER_WIDTH = 2,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned GAP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TDEST_WIDTH-1:0]    cfg_tdest,
    input  logic [TID_WIDTH-1:0]      cfg_tid,
    input  logic [TUSER_WIDTH-1:0]    cfg_tuser,
    input  logic [LEN_WIDTH-1:0]      cfg_len,
    input  logic [CNT_WIDTH-1:0]      cfg_num_pkts,
    input  logic [GAP_WIDTH-1:0]      cfg_gap,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH*8-1:0]   m_axis_tdata,
    output logic [TDEST_WIDTH-1:0]    m_axis_tdest,
    output logic [TID_WIDTH-1:0]      m_axis_tid,
    output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      pkt_count
);

    localparam int unsigned TDW = DATA_WIDTH * 8;

    state_t                   r_state;
    logic [LEN_WIDTH-1:0]     r_len;
    logic [LEN_WIDTH-1:0]     r_beat;
    logic [CNT_WIDTH-1:0]     r_num_pkts;
    logic [GAP_WIDTH-1:0]     r_gap;
    logic [GAP_WIDTH-1:0]     r_gap_cnt;
    logic [TDW-1:0]           r_tdata;
    logic [TDEST_WIDTH-1:0]   r_tdest;
    logic [TID_WIDTH-1:0]     r_tid;
    logic [TUSER_WIDTH-1:0]   r_tuser;
    logic                     r_tvalid;
    logic                     r_tlast;
    logic                     r_busy;
    logic                     r_done;
    logic [CNT_WIDTH-1:0]     r_pkt_count;

    logic                     w_accept;
    logic                     w_last_pkt;
    logic [TDW-1:0]           w_first_data;
    logic [TDW-1:0]           w_next_data;

    assign w_accept   = r_tvalid && m_axis_tready;
    assign w_last_pkt = (r_pkt_count + CNT_WIDTH'(1)) == r_num_pkts;

`ifdef AXIS_PACKET_GEN_LFSR_EN
    logic [63:0] w_lfsr_state;
    logic [63:0] w_lfsr_next;

    axis_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_load    ((r_state == IDLE) && start),
        .i_advance ((r_state == SEND) && w_accept),
        .o_state   (w_lfsr_state),
        .o_next    (w_lfsr_next)
    );

    // tdata is loaded with the value the LFSR will hold after this accept.
    assign w_first_data = LFSR_SEED[TDW-1:0];
    assign w_next_data  = w_lfsr_next[TDW-1:0];
`else
    assign w_first_data = '0;
    assign w_next_data  = r_tdata + TDW'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_beat      <= '0;
            r_num_pkts  <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_tdata     <= '0;
            r_tdest     <= '0;
            r_tid       <= '0;
            r_tuser     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len       <= cfg_len;
                        r_num_pkts  <= cfg_num_pkts;
                        r_gap       <= cfg_gap;
                        r_tdest     <= cfg_tdest;
                        r_tid       <= cfg_tid;
                        r_tuser     <= cfg_tuser;
                        r_pkt_count <= '0;
                        r_busy      <= 1'b1;
                        r_tdata     <= w_first_data;
                        r_beat      <= '0;
                        r_tlast     <= (cfg_len == '0);
                        if (cfg_num_pkts == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_tvalid <= 1'b1;
                            r_state  <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_tdata <= w_next_data;
                        if (r_tlast) begin
                            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
                            r_beat      <= '0;
                            r_tlast     <= (r_len == '0);
                            if (w_last_pkt) begin
                                r_tvalid <= 1'b0;
                                r_state  <= DONE;
                            end else if (r_gap != '0) begin
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= r_gap - GAP_WIDTH'(1);
                                r_state   <= GAP;
                            end
                        end else begin
                            r_beat  <= r_beat + LEN_WIDTH'(1);
                            r_tlast <= ((r_beat + LEN_WIDTH'(1)) == r_len);
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_tvalid <= 1'b1;
                        r_state  <= SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tdest  = r_tdest;
    assign m_axis_tid    = r_tid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Scoreboard bench for axis_packet_gen: a run model queues expected beats and
// results; a negedge monitor checks every accepted beat, hold, gap and done.
module tb_axis_packet_gen;
    import axis_gen_pkg::*;

    localparam int DW  = 2;
    localparam int TDW = 4;
    localparam int TIW = 2;
    localparam int TUW = 2;
    localparam int LW  = 8;
    localparam int CW  = 16;
    localparam int GW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [TDW-1:0]  cfg_tdest = '0;
    logic [TIW-1:0]  cfg_tid = '0;
    logic [TUW-1:0]  cfg_tuser = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic [CW-1:0]   cfg_num_pkts = '0;
    logic [GW-1:0]   cfg_gap = '0;
    logic            m_axis_tready = 1'b1;
    logic [DW*8-1:0] m_axis_tdata;
    logic [TDW-1:0]  m_axis_tdest;
    logic [TIW-1:0]  m_axis_tid;
    logic [TUW-1:0]  m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            busy;
    logic            done;
    logic [CW-1:0]   pkt_count;

    always #5 clk = ~clk;

    axis_packet_gen #(
        .DATA_WIDTH  (DW),
        .TDEST_WIDTH (TDW),
        .TID_WIDTH   (TIW),
        .TUSER_WIDTH (TUW),
        .LEN_WIDTH   (LW),
        .CNT_WIDTH   (CW),
        .GAP_WIDTH   (GW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_tdest     (cfg_tdest),
        .cfg_tid       (cfg_tid),
        .cfg_tuser     (cfg_tuser),
        .cfg_len       (cfg_len),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_gap       (cfg_gap),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .pkt_count     (pkt_count)
    );

    typedef struct {
        logic [DW*8-1:0] data;
        logic            last;
        logic [TDW-1:0]  tdest;
        logic [TIW-1:0]  tid;
        logic [TUW-1:0]  tuser;
        int              gap_after;   // -1 after the final beat of a run
    } beat_t;

    beat_t exp_q[$];
    int    exp_cnt_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference payload sequence derived from the payload rules.
    function automatic logic [63:0] first_word();
`ifdef AXIS_PACKET_GEN_LFSR_EN
        return LFSR_SEED;
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] next_word(input logic [63:0] w);
`ifdef AXIS_PACKET_GEN_LFSR_EN
        logic [63:0] mask;
        mask = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
        return w[0] ? ((w >> 1) ^ mask) : (w >> 1);
`else
        return w + 64'd1;
`endif
    endfunction

    task automatic push_run(input int len, input int num, input int gap,
                            input logic [TDW-1:0] td, input logic [TIW-1:0] ti,
                            input logic [TUW-1:0] tu);
        logic [63:0] w;
        beat_t b;
        w = first_word();
        for (int p = 0; p < num; p++) begin
            for (int k = 0; k <= len; k++) begin
                b.data  = w[DW*8-1:0];
                b.last  = (k == len);
                b.tdest = td;
                b.tid   = ti;
                b.tuser = tu;
                b.gap_after = (k != len) ? 0 : ((p == num - 1) ? -1 : gap);
                exp_q.push_back(b);
                w = next_word(w);
            end
        end
        exp_cnt_q.push_back(num);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready();
        if (rdy_mode == 0) m_axis_tready = 1'b1;
        else               m_axis_tready = ($urandom_range(0, 3) != 0);
    endtask

    // Called at posedge+1; returns at the negedge of the first cycle after start.
    task automatic do_start(input int len, input int num, input int gap,
                            input logic [TDW-1:0] td, input logic [TIW-1:0] ti,
                            input logic [TUW-1:0] tu);
        cfg_len      = len[LW-1:0];
        cfg_num_pkts = num[CW-1:0];
        cfg_gap      = gap[GW-1:0];
        cfg_tdest    = td;
        cfg_tid      = ti;
        cfg_tuser    = tu;
        start        = 1'b1;
        push_run(len, num, gap, td, ti, tu);
        step();
        start        = 1'b0;
        cfg_len      = LW'($urandom);
        cfg_num_pkts = CW'($urandom);
        cfg_gap      = GW'($urandom);
        cfg_tdest    = TDW'($urandom);
        @(negedge clk);
        chk("start_latency_tvalid", {63'd0, m_axis_tvalid}, {63'd0, (num != 0)});
        chk("start_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input bit inject);
        int seen;
        int i;
        seen = done_cnt;
        i = 0;
        while (done_cnt == seen && i < 600) begin
            step();
            drive_ready();
            if (inject && i == 1) begin
                cfg_num_pkts = CW'($urandom_range(1, 5));
                cfg_len      = LW'($urandom_range(0, 3));
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            i++;
        end
        start = 1'b0;
        chk("done_within_budget", {63'd0, done_cnt != seen}, 64'd1);
        chk("all_beats_consumed", exp_q.size(), 64'd0);
    endtask

    // Monitor: checks at negedge, away from the active edge.
    logic            hold_pend = 1'b0;
    logic [DW*8-1:0] hold_data;
    logic            hold_last;
    logic            gap_pend = 1'b0;
    int              gap_exp;
    int              idle_cnt;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_pend = 1'b0;
            gap_pend  = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                chk("hold_tdata", {48'd0, m_axis_tdata}, {48'd0, hold_data});
                chk("hold_tlast", {63'd0, m_axis_tlast}, {63'd0, hold_last});
                hold_pend = 1'b0;
            end
            if (m_axis_tvalid) begin
                if (gap_pend) begin
                    chk("gap_cycles", idle_cnt, gap_exp);
                    gap_pend = 1'b0;
                end
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got tdata=%0h, expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", {48'd0, m_axis_tdata}, {48'd0, e.data});
                        chk("tlast", {63'd0, m_axis_tlast}, {63'd0, e.last});
                        chk("tdest", {60'd0, m_axis_tdest}, {60'd0, e.tdest});
                        chk("tid_tuser", {60'd0, m_axis_tid, m_axis_tuser},
                            {60'd0, e.tid, e.tuser});
                        if (e.last && e.gap_after >= 0) begin
                            gap_pend = 1'b1;
                            gap_exp  = e.gap_after;
                            idle_cnt = 0;
                        end
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_data = m_axis_tdata;
                    hold_last = m_axis_tlast;
                end
            end else if (gap_pend) begin
                idle_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", {63'd0, busy}, 64'd0);
                if (exp_cnt_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got pkt_count=%0d, expected no done", pkt_count);
                end else begin
                    chk("pkt_count", {48'd0, pkt_count}, exp_cnt_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, num, gap, total;
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("reset_outputs", {m_axis_tdata, m_axis_tdest, m_axis_tid, m_axis_tuser,
                              m_axis_tlast, busy, done, pkt_count}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // Back-to-back packets, word counter 0..7.
        rdy_mode = 0;
        do_start(3, 2, 0, 4'h3, 2'd1, 2'd2);
        wait_done(1'b0);

        // Single-beat packets separated by gaps.
        step();
        do_start(0, 3, 2, 4'h5, 2'd0, 2'd1);
        wait_done(1'b0);

        // tready held low for five cycles on beat 0.
        step();
        m_axis_tready = 1'b0;
        do_start(1, 1, 0, 4'h9, 2'd3, 2'd3);
        chk("stall_tdata_first", {48'd0, m_axis_tdata}, {48'd0, first_word() & 64'hFFFF});
        chk("stall_tlast", {63'd0, m_axis_tlast}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            m_axis_tready = 1'b0;
            @(negedge clk);
            chk("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        end
        wait_done(1'b0);

        // Empty run: done two cycles after start, no beats.
        step();
        do_start(2, 0, 1, 4'h1, 2'd0, 2'd0);
        @(negedge clk);
        chk("empty_done_pulse", {63'd0, done}, 64'd1);
        chk("empty_pkt_count", {48'd0, pkt_count}, 64'd0);
        chk("empty_no_tvalid", {63'd0, m_axis_tvalid}, 64'd0);

        // Start during a run must be ignored.
        step();
        rdy_mode = 1;
        do_start(2, 3, 1, 4'hA, 2'd2, 2'd0);
        wait_done(1'b1);

        // Reset in the middle of a packet, then a fresh run.
        rdy_mode = 0;
        step();
        do_start(3, 1, 0, 4'h7, 2'd1, 2'd1);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("midreset_outputs", {m_axis_tdata, m_axis_tdest, m_axis_tid, m_axis_tuser,
                                 m_axis_tlast, busy, done, pkt_count}, 64'd0);
        exp_q.delete();
        exp_cnt_q.delete();
        step();
        rst = 1'b0;
        step();
        do_start(2, 1, 0, 4'hC, 2'd0, 2'd3);
        chk("fresh_tdest", {60'd0, m_axis_tdest}, 64'hC);
        wait_done(1'b0);

        // Randomized runs under random backpressure.
        for (int r = 0; r < 14; r++) begin
            rdy_mode = 1;
            len = $urandom_range(0, 4);
            num = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            total = (len + 1) * num;
            step();
            do_start(len, num, gap, TDW'($urandom), TIW'($urandom), TUW'($urandom));
            wait_done(total >= 3);
        end

        step();
        step();
        chk("final_idle_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
